// File: rtl/tim_pkg.sv
// tim_pkg: shared register offsets and APB protocol state type for the timer IP
package tim_pkg;
  localparam logic [31:0] TIM_INT_EN_OFS   = 32'h0;
  localparam logic [31:0] TIM_INT_STAT_OFS = 32'h4;
  localparam logic [31:0] TIM_INT_CNT_OFS  = 32'h8;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t;
endpackage

// File: rtl/tim_apb_fsm.sv
// tim_apb_fsm: APB responder phase tracking, zero-wait ready/error and register enables
module tim_apb_fsm
  import tim_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic addr_ok,
  output logic pready,
  output logic pslverr,
  output logic acc,
  output logic wr_en
);
  apb_state_t st, st_nx;
  logic xfer, bad;
  // st holds the bus phase of the previous cycle; a legal access must follow a setup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= APB_IDLE;
    else        st <= st_nx;
  end
  // access cycles answer in the same cycle; penable without a preceding setup is an error
  always_comb begin
    xfer    = psel & penable & (st == APB_SETUP);
    bad     = psel & penable & (st != APB_SETUP);
    st_nx   = ~psel ? APB_IDLE : ~penable ? APB_SETUP : (st == APB_SETUP) ? APB_ACCESS : APB_IDLE;
    pready  = xfer | bad;
    pslverr = bad | (xfer & ~addr_ok);
    acc     = xfer & addr_ok;
    wr_en   = acc & pwrite;
  end
endmodule

// File: rtl/tim_int_status.sv
// tim_int_status: sticky timer interrupt status, enable and event-count registers on APB
module tim_int_status
  import tim_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_match,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              int_en,
  output logic              int_st,
  output logic              int_st_set,
  output logic              int_st_clear
);
  logic             cmp_match_d, armed;
  logic             sel_en, sel_stat, sel_cnt, addr_ok;
  logic             acc, wr_en, w1c, cnt_wr;
  logic [CNT_W-1:0] cnt;
  logic             unused_ok;
  tim_apb_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .addr_ok (addr_ok),
    .pready  (pready),
    .pslverr (pslverr),
    .acc     (acc),
    .wr_en   (wr_en)
  );
  assign unused_ok = &{1'b0, pwdata[31:1]};
  // address decode, edge detect and read mux; armed masks a level already high at reset release
  always_comb begin
    sel_en     = paddr == ADDR_W'(TIM_INT_EN_OFS);
    sel_stat   = paddr == ADDR_W'(TIM_INT_STAT_OFS);
    sel_cnt    = paddr == ADDR_W'(TIM_INT_CNT_OFS);
    addr_ok    = sel_en | sel_stat | sel_cnt;
    int_st_set = armed & cmp_match & ~cmp_match_d;
    w1c        = wr_en & sel_stat & pwdata[0];
    cnt_wr     = wr_en & sel_cnt;
    prdata     = ~acc     ? 32'h0 :
                 sel_en   ? {31'h0, int_en} :
                 sel_stat ? {30'h0, int_st & int_en, int_st} :
                            32'(cnt);
  end
  // register state: set beats clear, and a clear pulse only follows a clear that took effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_match_d  <= 1'b0;
      armed        <= 1'b0;
      int_en       <= 1'b0;
      int_st       <= 1'b0;
      int_st_clear <= 1'b0;
      cnt          <= '0;
    end else begin
      cmp_match_d  <= cmp_match;
      armed        <= 1'b1;
      int_en       <= (wr_en & sel_en) ? pwdata[0] : int_en;
      int_st       <= int_st_set | (int_st & ~w1c);
      int_st_clear <= w1c & ~int_st_set;
      cnt          <= cnt_wr ? CNT_W'(int_st_set) :
                      (int_st_set & ~&cnt) ? cnt + 1'b1 : cnt;
    end
  end
endmodule
